// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, word size
// and wait-state counter width.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WORD_BYTES = 2;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read.
// Contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   // write port
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for mem-stage load/store requests. Accepts one
// request per handshake, waits WAIT_CYCLES, commits the access on the edge
// entering RESP and holds the response until resp_ready.
// Optional macro DMEM_MISALIGN_TRAP_EN: odd byte addresses are trapped
// (no write, rdata=0, resp_err=1); without it bit 0 is ignored.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  stall
);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  commit;
   logic                  accept;

   logic                  cur_we;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic                  mis;
   logic                  arr_we;
   logic [DATA_WIDTH-1:0] arr_rdata;
   logic                  unused_addr_bits;

   // With zero wait states the commit happens on the accept edge, before the
   // latch holds anything, so the live request feeds the array in IDLE.
   assign cur_we    = (state_q == IDLE) ? req_we    : lat_we;
   assign cur_addr  = (state_q == IDLE) ? req_addr  : lat_addr;
   assign cur_wdata = (state_q == IDLE) ? req_wdata : lat_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis = cur_addr[0];
`else
   assign mis = 1'b0;
`endif

   // High address bits alias; bit 0 is the byte offset.
   assign unused_addr_bits = ^{cur_addr[ADDR_WIDTH-1:DEPTH_LOG2+1], cur_addr[0]};

   assign accept     = (state_q == IDLE) && req_valid;
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign stall      = (state_q != IDLE) || req_valid;
   assign arr_we     = commit && cur_we && !mis;

   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clock (clock),
      .we    (arr_we),
      .addr  (cur_addr[DEPTH_LOG2:1]),
      .wdata (cur_wdata),
      .rdata (arr_rdata)
   );

   // next-state, counter and commit strobe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_d = CNT_W'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               commit  = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and wait counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // request capture, only at acceptance
   always_ff @(posedge clock) begin
      if (reset) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
   end

   // load data register: set on commit, held through RESP, cleared on handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_rdata <= '0;
      end else if (commit) begin
         resp_rdata <= (cur_we || mis) ? '0 : arr_rdata;
      end else if ((state_q == RESP) && resp_ready) begin
         resp_rdata <= '0;
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   // misalignment flag, same lifetime as the load data
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_err <= 1'b0;
      end else if (commit) begin
         resp_err <= mis;
      end else if ((state_q == RESP) && resp_ready) begin
         resp_err <= 1'b0;
      end
   end
`else
   assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, sharing a request bus selected by 'sel'.
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        sel;
   logic        req_valid, req_we, resp_ready;
   logic [15:0] req_addr, req_wdata;

   logic        rv_a, rv_b, rr_a, rr_b;
   logic        req_ready_a, req_ready_b, resp_valid_a, resp_valid_b;
   logic        resp_err_a, resp_err_b, stall_a, stall_b;
   logic [15:0] rdata_a, rdata_b;

   logic        req_ready, resp_valid, resp_err, stall;
   logic [15:0] resp_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   assign rv_a = req_valid  & ~sel;
   assign rv_b = req_valid  &  sel;
   assign rr_a = resp_ready & ~sel;
   assign rr_b = resp_ready &  sel;

   assign req_ready  = sel ? req_ready_b  : req_ready_a;
   assign resp_valid = sel ? resp_valid_b : resp_valid_a;
   assign resp_err   = sel ? resp_err_b   : resp_err_a;
   assign stall      = sel ? stall_b      : stall_a;
   assign resp_rdata = sel ? rdata_b      : rdata_a;

   dmem_responder #(.WAIT_CYCLES(2)) dut_a (
      .clock(clock), .reset(reset),
      .req_valid(rv_a), .req_ready(req_ready_a), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_a), .resp_ready(rr_a), .resp_rdata(rdata_a),
      .resp_err(resp_err_a), .stall(stall_a)
   );

   dmem_responder #(.WAIT_CYCLES(0)) dut_b (
      .clock(clock), .reset(reset),
      .req_valid(rv_b), .req_ready(req_ready_b), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_b), .resp_ready(rr_b), .resp_rdata(rdata_b),
      .resp_err(resp_err_b), .stall(stall_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // present a request for exactly one accept cycle, then scramble the bus
   task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
      req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
      #1;
      check("accept_ready", {31'd0, req_ready}, 32'd1);
      check("accept_stall", {31'd0, stall}, 32'd1);
      step();
      req_valid = 1'b0; req_we = ~we; req_addr = 16'hFFFF; req_wdata = 16'h5A5A;
   endtask

   // edges from the accept edge until resp_valid, bounded
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         check("wait_stall", {31'd0, stall}, 32'd1);
         check("wait_ready", {31'd0, req_ready}, 32'd0);
         step();
         lat++;
      end
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("post_valid", {31'd0, resp_valid}, 32'd0);
      check("post_rdata", {16'd0, resp_rdata}, 32'd0);
      check("post_ready", {31'd0, req_ready}, 32'd1);
      check("post_stall", {31'd0, stall}, 32'd0);
   endtask

   task automatic txn(input string tag, input logic we, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] exp_rd,
                      input logic exp_err, input int exp_lat);
      int lat;
      issue(we, a, d);
      wait_resp(lat);
      check({tag, "_lat"},   lat, exp_lat);
      check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_stall"}, {31'd0, stall}, 32'd1);
      check({tag, "_rdata"}, {16'd0, resp_rdata}, {16'd0, exp_rd});
      check({tag, "_err"},   {31'd0, resp_err}, {31'd0, exp_err});
      finish_resp();
   endtask

   initial begin
      int lat;
      sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();

      // reset state
      check("rst_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", {16'd0, resp_rdata}, 32'd0);
      check("rst_err",   {31'd0, resp_err}, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_stall", {31'd0, stall}, 32'd0);

      // store then load, two wait states
      txn("st_beef", 1'b1, 16'h0004, 16'hBEEF, 16'h0000, 1'b0, 3);
      txn("ld_beef", 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 3);

      // backpressure: response held, request pulse ignored
      issue(1'b0, 16'h0004, 16'h0000);
      wait_resp(lat);
      check("bp_lat", lat, 3);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0004; req_wdata = 16'hDEAD;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         check("bp_valid", {31'd0, resp_valid}, 32'd1);
         check("bp_rdata", {16'd0, resp_rdata}, 32'h0000BEEF);
         check("bp_ready", {31'd0, req_ready}, 32'd0);
         step();
      end
      req_valid = 1'b0;
      finish_resp();
      txn("bp_reload", 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0, 3);

      // address wrap: 0x0806 aliases 0x0006
      txn("wrap_st", 1'b1, 16'h0806, 16'hA5A5, 16'h0000, 1'b0, 3);
      txn("wrap_ld", 1'b0, 16'h0006, 16'h0000, 16'hA5A5, 1'b0, 3);

      // reset during WAIT drops an uncommitted store
      txn("pre_st", 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0, 3);
      issue(1'b1, 16'h0020, 16'h7777);
      check("mid_inwait", {31'd0, req_ready}, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_ready", {31'd0, req_ready}, 32'd1);
      check("mid_valid", {31'd0, resp_valid}, 32'd0);
      check("mid_stall", {31'd0, stall}, 32'd0);
      repeat (3) step();
      check("mid_quiet", {31'd0, resp_valid}, 32'd0);
      txn("mid_ld", 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 3);

      // odd byte address
`ifdef DMEM_MISALIGN_TRAP_EN
      txn("mis_st", 1'b1, 16'h0021, 16'hFFFF, 16'h0000, 1'b1, 3);
      txn("mis_chk", 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 3);
      txn("mis_ld", 1'b0, 16'h0021, 16'h0000, 16'h0000, 1'b1, 3);
`else
      txn("odd_st", 1'b1, 16'h0021, 16'hFFFF, 16'h0000, 1'b0, 3);
      txn("odd_chk", 1'b0, 16'h0020, 16'h0000, 16'hFFFF, 1'b0, 3);
      txn("odd_ld", 1'b0, 16'h0021, 16'h0000, 16'hFFFF, 1'b0, 3);
`endif

      // zero wait states
      sel = 1'b1;
      #1;
      check("z_idle_stall", {31'd0, stall}, 32'd0);
      step();
      txn("z_st", 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1);
      txn("z_ld", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1);
      txn("z_wrap", 1'b0, 16'h0810, 16'h0000, 16'h1234, 1'b0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
